// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared definitions for the scroll_addr_gen frame-buffer address generator:
//   - state_e : scroller FSM states (PAUSE, RUN, HOMING)
//   - DIR_*   : encoding of the 2-bit scroll direction input
// -----------------------------------------------------------------------------
package scroll_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    HOMING = 2'd2
  } state_e;

  localparam logic [1:0] DIR_LEFT  = 2'b00;  // x_off increases
  localparam logic [1:0] DIR_RIGHT = 2'b01;  // x_off decreases
  localparam logic [1:0] DIR_UP    = 2'b10;  // y_off increases
  localparam logic [1:0] DIR_DOWN  = 2'b11;  // y_off decreases

endpackage

// File: rtl/scroll_addr_gen_if.sv
// -----------------------------------------------------------------------------
// scroll_addr_gen_if
// Video-side bus between the VGA timing source and scroll_addr_gen.
//   h_cnt, v_cnt  : VGA pixel/line counters (10 bits each)
//   valid         : VGA active-area flag
//   pixel_addr    : ROM pixel address (ADDR_W bits), 2 cycles after h/v_cnt
//   addr_valid    : valid, delayed to line up with pixel_addr
// Modports:
//   master : VGA side (drives counters, receives the address)
//   slave  : address generator
// -----------------------------------------------------------------------------
interface scroll_addr_gen_if #(
  parameter int ADDR_W = 17
);
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              valid;
  logic [ADDR_W-1:0] pixel_addr;
  logic              addr_valid;

  modport master (
    output h_cnt, v_cnt, valid,
    input  pixel_addr, addr_valid
  );

  modport slave (
    input  h_cnt, v_cnt, valid,
    output pixel_addr, addr_valid
  );
endinterface

// File: rtl/wrap_addsub.sv
// -----------------------------------------------------------------------------
// wrap_addsub
// Combinational modular add/subtract: y = (a + b) mod N or (a - b) mod N.
// Operands must already satisfy a < N and b < N, so one conditional
// correction by N is enough.
// Ports:
//   a, b : operands (W bits, each < N)
//   sub  : 0 = add, 1 = subtract
//   y    : result in [0, N-1]
// -----------------------------------------------------------------------------
module wrap_addsub #(
  parameter int N = 320,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  localparam logic [W:0] MOD = (W+1)'(N);

  logic [W:0] sum;
  logic [W:0] diff;

  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};   // MSB set means a borrow occurred
    y    = '0;
    if (sub) begin
      y = diff[W] ? W'(diff + MOD) : diff[W-1:0];
    end else begin
      y = (sum >= MOD) ? W'(sum - MOD) : sum[W-1:0];
    end
  end

endmodule

// File: rtl/scroll_addr_gen.sv
// -----------------------------------------------------------------------------
// scroll_addr_gen
// Maps VGA h_cnt/v_cnt to a frame-buffer pixel address with integer
// down-scaling, two-axis wrap-around scrolling, optional mirroring and a
// homing mode that walks both offsets back to zero.
//
// Optional feature macro: SCROLL_MIRROR_EN
//   defined   : mirror_h / mirror_v flip the source image
//   undefined : mirror logic is not built, mirror_h / mirror_v are ignored
//
// Ports:
//   clk       pixel clock
//   rst       asynchronous, active-high reset
//   tick      one-cycle scroll-update strobe
//   en        1 = scroll, 0 = hold
//   home      one-cycle pulse, starts homing
//   dir       scroll direction (see scroll_pkg DIR_*)
//   step      pixels moved per tick
//   mirror_h  mirror source horizontally
//   mirror_v  mirror source vertically
//   busy      high while homing
//   vga       video bus (h_cnt, v_cnt, valid in; pixel_addr, addr_valid out)
// -----------------------------------------------------------------------------
module scroll_addr_gen
  import scroll_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int STEP_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en,
  input  logic              home,
  input  logic [1:0]        dir,
  input  logic [STEP_W-1:0] step,
  input  logic              mirror_h,
  input  logic              mirror_v,
  output logic              busy,
  scroll_addr_gen_if.slave  vga
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [1:0] ST_PAUSE  = 2'(PAUSE);
  localparam logic [1:0] ST_RUN    = 2'(RUN);
  localparam logic [1:0] ST_HOMING = 2'(HOMING);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  // ---------------------------------------------------------------------------
  // Effective step: saturated below IMG_H so that each offset update needs at
  // most one modulus correction on either axis.
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] es;
  logic [XW-1:0]     es_x;
  logic [YW-1:0]     es_y;

  always_comb begin
    es = step;
    if (int'(step) > IMG_H - 1) es = STEP_W'(IMG_H - 1);
  end

  assign es_x = XW'(es);
  assign es_y = YW'(es);

  // ---------------------------------------------------------------------------
  // Working offsets and FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic [XW-1:0] x_step;
  logic [YW-1:0] y_step;
  logic [XW-1:0] x_home;
  logic [YW-1:0] y_home;

  wrap_addsub #(.N(IMG_W), .W(XW)) u_x_step (
    .a   (x_off),
    .b   (es_x),
    .sub (dir == DIR_RIGHT),
    .y   (x_step)
  );

  wrap_addsub #(.N(IMG_H), .W(YW)) u_y_step (
    .a   (y_off),
    .b   (es_y),
    .sub (dir == DIR_DOWN),
    .y   (y_step)
  );

  // Homing walks toward zero and saturates there; it never wraps.
  assign x_home = (x_off > es_x) ? x_off - es_x : '0;
  assign y_home = (y_off > es_y) ? y_off - es_y : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PAUSE:  if (home) state_nxt = ST_HOMING;
                 else if (en) state_nxt = ST_RUN;
      ST_RUN:    if (home) state_nxt = ST_HOMING;
                 else if (!en) state_nxt = ST_PAUSE;
      ST_HOMING: if (x_off == '0 && y_off == '0) state_nxt = ST_PAUSE;
      default:   state_nxt = ST_PAUSE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PAUSE;
      busy  <= 1'b0;
      x_off <= '0;
      y_off <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_HOMING);
      // A tick that coincides with home is handled by the current state,
      // so it is a RUN (or ignored PAUSE) tick rather than a homing tick.
      if (tick) begin
        case (state)
          ST_RUN: begin
            if (dir[1]) y_off <= y_step;
            else        x_off <= x_step;
          end
          ST_HOMING: begin
            x_off <= x_home;
            y_off <= y_home;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow offsets, committed once per frame at (0,0). The first pixel of the
  // frame uses the value being committed so the whole frame sees one offset.
  // ---------------------------------------------------------------------------
  logic          commit;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;
  logic [XW-1:0] x_base;
  logic [YW-1:0] y_base;

  assign commit = (vga.h_cnt == '0) && (vga.v_cnt == '0);
  assign x_base = commit ? x_off : x_cur;
  assign y_base = commit ? y_off : y_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cur <= '0;
      y_cur <= '0;
    end else if (commit) begin
      x_cur <= x_off;
      y_cur <= y_off;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: scale, clamp, mirror, add scroll offset
  // ---------------------------------------------------------------------------
  logic [9:0]    sx_full;
  logic [9:0]    sy_full;
  logic [XW-1:0] sx_c;
  logic [YW-1:0] sy_c;
  logic [XW-1:0] sx_m;
  logic [YW-1:0] sy_m;
  logic [XW-1:0] x_sum;
  logic [YW-1:0] y_sum;

  assign sx_full = vga.h_cnt >> SCALE_SHIFT;
  assign sy_full = vga.v_cnt >> SCALE_SHIFT;
  assign sx_c    = (int'(sx_full) > IMG_W - 1) ? X_MAX : XW'(sx_full);
  assign sy_c    = (int'(sy_full) > IMG_H - 1) ? Y_MAX : YW'(sy_full);

`ifdef SCROLL_MIRROR_EN
  assign sx_m = mirror_h ? X_MAX - sx_c : sx_c;
  assign sy_m = mirror_v ? Y_MAX - sy_c : sy_c;
`else
  logic unused_mirror;
  assign unused_mirror = mirror_h ^ mirror_v;
  assign sx_m = sx_c;
  assign sy_m = sy_c;
`endif

  wrap_addsub #(.N(IMG_W), .W(XW)) u_x_add (
    .a   (sx_m),
    .b   (x_base),
    .sub (1'b0),
    .y   (x_sum)
  );

  wrap_addsub #(.N(IMG_H), .W(YW)) u_y_add (
    .a   (sy_m),
    .b   (y_base),
    .sub (1'b0),
    .y   (y_sum)
  );

  logic [XW-1:0] x_s1;
  logic [YW-1:0] y_s1;
  logic          valid_s1;

  // NOTE: pipeline registers are plain flops (not a memory), so they are
  // cheap to reset and the reset keeps stale addresses off the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s1     <= '0;
      y_s1     <= '0;
      valid_s1 <= 1'b0;
    end else begin
      x_s1     <= x_sum;
      y_s1     <= y_sum;
      valid_s1 <= vga.valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: linear address
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_s2;
  logic              valid_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_s2  <= '0;
      valid_s2 <= 1'b0;
    end else begin
      addr_s2  <= ADDR_W'(y_s1) * ADDR_W'(IMG_W) + ADDR_W'(x_s1);
      valid_s2 <= valid_s1;
    end
  end

  assign vga.pixel_addr = addr_s2;
  assign vga.addr_valid = valid_s2;

endmodule
